// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prem, sreg, dvs;
    logic [WIDTH-1:0] prem_nxt, sreg_nxt;
    logic [WIDTH:0]   shifted, trial;
    logic             accept;

    assign accept   = (state == IDLE) && in_valid;
    assign shifted  = {prem, sreg[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs};
    // A set MSB means the trial went negative: restore by keeping the shifted value.
    assign prem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign sreg_nxt = {sreg[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (in_valid ? (divisor == '0 ? DONE : RUN) : IDLE) :
                    (state == RUN)  ? (count == CW'(1) ? DONE : RUN) :
                                      (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == RUN;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            prem        <= '0;
            sreg        <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= CW'(WIDTH);
            prem        <= '0;
            sreg        <= dividend;
            dvs         <= divisor;
            div_by_zero <= divisor == '0;
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            count <= count - CW'(1);
            prem  <= prem_nxt;
            sreg  <= sreg_nxt;
            if (count == CW'(1)) begin
                quotient  <= sreg_nxt;
                remainder <= prem_nxt;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (WIDTH=8).
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       in_ready, out_valid, div_by_zero, busy;
    logic [7:0] quotient, remainder;
    int         n_checks = 0;
    int         n_fails = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one operation at a negedge, checks latency/busy/results, optionally completes the handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          input bit release_out, input string tag);
        int lat, nbusy;
        logic [7:0] eq, er;
        eq = (b == 0) ? 8'hFF : 8'(a / b);
        er = (b == 0) ? a : 8'(a % b);
        out_ready = 1'b0;
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!out_valid && lat < 40) begin
            nbusy += 32'(busy);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
        chk({tag, "_busy_cycles"}, nbusy, (b == 0) ? 0 : 8);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
        if (b != 0) begin
            chk({tag, "_identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk({tag, "_rem_lt_div"}, 32'(remainder < b), 1);
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({tag, "_held_valid"}, 32'(out_valid), 1);
            chk({tag, "_held_q"}, 32'(quotient), 32'(eq));
        end
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(out_valid), 0);
            chk({tag, "_q_kept"}, 32'(quotient), 32'(eq));
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_q", 32'(quotient), 0);
        chk("reset_r", 32'(remainder), 0);
        chk("reset_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);

        run_op(8'd100, 8'd7, 0, 1'b1, "d100_7");
        run_op(8'd255, 8'd1, 0, 1'b1, "d255_1");
        run_op(8'd5, 8'd10, 0, 1'b1, "d5_10");
        run_op(8'd255, 8'd255, 0, 1'b1, "d255_255");
        run_op(8'd0, 8'd3, 0, 1'b1, "d0_3");
        run_op(8'd42, 8'd0, 0, 1'b1, "d42_0");
        run_op(8'd9, 8'd3, 0, 1'b1, "d9_3");

        // Backpressure with competing operands offered while DONE.
        run_op(8'd77, 8'd5, 0, 1'b0, "d77_5");
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_q", 32'(quotient), 15);
            chk("bp_r", 32'(remainder), 2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_in_ready", 32'(in_ready), 1);
        run_op(8'd200, 8'd10, 0, 1'b1, "d200_10");

        // Reset during RUN aborts the operation.
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", 32'(out_valid), 0);
        chk("midrun_busy", 32'(busy), 0);
        chk("midrun_q", 32'(quotient), 0);
        chk("midrun_r", 32'(remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd50, 8'd6, 0, 1'b1, "d50_6");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring unsigned divider: the inverse operation of the team's array multiplier, and the companion block on the same tile.
- Accepts a dividend/divisor pair through a valid/ready handshake and computes one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag through a second valid/ready handshake.
- Sits behind the tt_um top-level pin mux; operands come from ui_in/uio_in and results go to uo_out/uio_out.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  set when the latched divisor was 0.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, iteration counter=0, all internal registers 0.
  - Outputs: quotient=0, remainder=0, div_by_zero=0, out_valid=0, busy=0, in_ready=1 once reset releases.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no result is produced.
- States IDLE, RUN, DONE. The state encoding is internal to the block.
- IDLE:
  - in_ready=1.
  - Operands are accepted on the rising edge where in_valid=1; dividend and divisor are latched on that edge (edge E0).
  - If the latched divisor != 0: go to RUN, counter=WIDTH, partial remainder (WIDTH+1 bits)=0, shift register=dividend, div_by_zero=0.
  - If the latched divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN, each cycle:
  - Shift {partial remainder, shift register} left by 1.
  - Trial = partial remainder − {0,divisor}.
  - If trial is non-negative (MSB=0): partial remainder=trial and the shifted-in quotient bit=1.
  - Otherwise: keep the partial remainder and the quotient bit=0.
  - Counter decrements. When the counter reaches 1 on an edge, the state moves to DONE on that edge.
  - RUN lasts exactly WIDTH cycles; busy=1 throughout; in_ready=0; operand inputs are ignored.
- DONE:
  - out_valid=1, and quotient/remainder/div_by_zero are stable.
  - On an edge with out_ready=1, go to IDLE; out_valid falls the next cycle.
  - out_valid stays high indefinitely while out_ready=0 (backpressure).
  - quotient, remainder and div_by_zero keep their last values in IDLE until the next accept.
- Latency:
  - Normal operation: out_valid rises after edge E0+WIDTH (WIDTH+1 cycles accept-to-valid, 9 for WIDTH=8).
  - Divide by zero: out_valid rises after edge E0 (1 cycle).
- Simultaneous events:
  - If the DONE→IDLE handshake and in_valid occur on the same edge, no operands are accepted, because in_ready=0 in DONE. The minimum issue interval is WIDTH+2 cycles.
  - in_valid held high in RUN/DONE is not queued.
- Arithmetic:
  - All operations are unsigned.
  - The result always satisfies dividend = quotient*divisor + remainder with remainder < divisor (divisor != 0).
  - No overflow is possible.
  - The partial remainder needs WIDTH+1 bits internally; only WIDTH bits are output.

Test Plan:
- Normal division: reset, then dividend=100, divisor=7 → out_valid exactly 9 cycles after accept; quotient=14, remainder=2, div_by_zero=0; busy high for 8 cycles.
- Corner quotients:
  - 255/1 → q=255, r=0.
  - 5/10 → q=0, r=5.
  - 255/255 → q=1, r=0.
  - 0/3 → q=0, r=0.
- Divide by zero: 42/0 → out_valid 1 cycle after accept; q=0xFF, r=42, div_by_zero=1. The next op 9/3 → q=3, r=0, div_by_zero=0.
- Backpressure and input blocking: out_ready=0 for 20 cycles after valid → out_valid and results held constant. Meanwhile in_valid=1 with 200/10 → not accepted (in_ready=0). Raise out_ready → IDLE; 200/10 is then accepted and yields q=20, r=0.
- Reset mid-RUN: 100/7 accepted; assert rst_n low at RUN cycle 4 → immediately out_valid=0, busy=0, q=0, r=0. After release, 50/6 → q=8, r=2 with normal latency.
- Randomized sweep: 1000 random pairs including divisor=0, with random out_ready → each result matches the reference model; the identity holds; latency is 9 (or 1 for divide by zero).
